// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers for the fxp_mult_pipe datapath: rounding, range check and limiting.
// All helpers work on a 128-bit signed container, so products up to 2*64 bits are supported.
package fxp_pkg;

  localparam int FXP_OVF_CNT_W = 16;
  localparam int FXP_MAX_PW    = 128;

  typedef logic signed [FXP_MAX_PW-1:0] fxp_wide_t;

  // Round half toward +inf, then drop the fractional bits.
  function automatic fxp_wide_t fxp_round(input fxp_wide_t product, input int frac);
    fxp_wide_t half;
    if (frac == 0) begin
      return product;
    end
    half = fxp_wide_t'(1) << (frac - 1);
    return (product + half) >>> frac;
  endfunction

  function automatic fxp_wide_t fxp_max(input int width);
    return (fxp_wide_t'(1) << (width - 1)) - fxp_wide_t'(1);
  endfunction

  function automatic logic fxp_ovf(input fxp_wide_t value, input int width);
    return (value > fxp_max(width)) || (value < (-fxp_max(width) - fxp_wide_t'(1)));
  endfunction

  function automatic fxp_wide_t fxp_limit(input fxp_wide_t value, input int width);
    if (value > fxp_max(width)) begin
      return fxp_max(width);
    end
    if (value < (-fxp_max(width) - fxp_wide_t'(1))) begin
      return -fxp_max(width) - fxp_wide_t'(1);
    end
    return value;
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round + range check + limit of a full-width product.
// FXP_MULT_SAT_EN selects clamping on overflow; otherwise the result wraps.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 15
) (
  input  logic signed [2*WIDTH-1:0] prod_i,
  output logic        [WIDTH-1:0]   res_o,
  output logic                      ovf_o
);

  fxp_wide_t rnd;

  assign rnd   = fxp_round(fxp_wide_t'(prod_i), FRAC);
  assign ovf_o = fxp_ovf(rnd, WIDTH);

`ifdef FXP_MULT_SAT_EN
  assign res_o = WIDTH'(fxp_limit(rnd, WIDTH));
`else
  assign res_o = rnd[WIDTH-1:0];
`endif

endmodule

// File: rtl/fxp_mult_pipe.sv
// Pipelined signed Q-format multiplier with valid/ready, round-to-nearest and overflow counting.
// Overflow handling is clamp when FXP_MULT_SAT_EN is defined, two's complement wrap otherwise.
module fxp_mult_pipe
  import fxp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 15,
  parameter int STAGES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  in_a,
  input  logic signed [WIDTH-1:0]  in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WIDTH-1:0]  out_c,
  output logic                     out_ovf,
  output logic [FXP_OVF_CNT_W-1:0] ovf_cnt,
  input  logic                     clr_ovf
);

  localparam int PW = 2 * WIDTH;
  // With four stages rounding is registered ahead of the limiter, which then sees FRAC=0.
  localparam int RS_FRAC = (STAGES == 4) ? 0 : FRAC;

  logic                     en;
  logic [STAGES-1:0]        vld_q;
  logic signed [WIDTH-1:0]  a_q, b_q;
  logic signed [PW-1:0]     prod_c;
  logic signed [PW-1:0]     rs_in;
  logic [WIDTH-1:0]         rs_res;
  logic                     rs_ovf;
  logic signed [WIDTH-1:0]  c_q;
  logic                     ovf_q;
  logic [FXP_OVF_CNT_W-1:0] cnt_q, cnt_d;

  // Whole pipeline freezes only when a result is waiting and not taken.
  assign en       = !(vld_q[STAGES-1] && !out_ready);
  assign in_ready = en;
  assign prod_c   = PW'(a_q) * PW'(b_q);

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      vld_q <= {vld_q[STAGES-2:0], in_valid};
      a_q   <= in_a;
      b_q   <= in_b;
      c_q   <= rs_res;
      ovf_q <= rs_ovf;
    end
  end

  generate
    if (STAGES == 2) begin : g_s2
      assign rs_in = prod_c;
    end else begin : g_prod
      logic signed [PW-1:0] prod_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prod_q <= '0;
        end else if (en) begin
          prod_q <= prod_c;
        end
      end

      if (STAGES == 3) begin : g_s3
        assign rs_in = prod_q;
      end else begin : g_s4
        logic signed [PW-1:0] rnd_q;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            rnd_q <= '0;
          end else if (en) begin
            rnd_q <= PW'(fxp_round(fxp_wide_t'(prod_q), FRAC));
          end
        end

        assign rs_in = rnd_q;
      end
    end
  endgenerate

  fxp_round_sat #(
    .WIDTH (WIDTH),
    .FRAC  (RS_FRAC)
  ) u_round_sat (
    .prod_i (rs_in),
    .res_o  (rs_res),
    .ovf_o  (rs_ovf)
  );

  // NOTE: default first in always_comb so no path leaves cnt_d unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_ovf) begin
      cnt_d = '0;
    end else if (out_valid && out_ready && ovf_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + FXP_OVF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_c     = c_q;
  assign out_ovf   = ovf_q;
  assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Self-checking bench: two instances (FRAC=0 and FRAC=15) share stimulus and are compared
// every cycle against a transaction-level model built from plain integer arithmetic.
module tb_fxp_mult_pipe;

  localparam int STAGES = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_a, in_b;
  logic        out_ready;
  logic        clr_ovf;

  logic        in_ready0, out_valid0, out_ovf0;
  logic [15:0] out_c0, ovf_cnt0;
  logic        in_ready15, out_valid15, out_ovf15;
  logic [15:0] out_c15, ovf_cnt15;

  always #5 clk = ~clk;

  fxp_mult_pipe #(.WIDTH(16), .FRAC(0), .STAGES(STAGES)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_c     (out_c0),
    .out_ovf   (out_ovf0),
    .ovf_cnt   (ovf_cnt0),
    .clr_ovf   (clr_ovf)
  );

  fxp_mult_pipe #(.WIDTH(16), .FRAC(15), .STAGES(STAGES)) u_dut15 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready15),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid15),
    .out_ready (out_ready),
    .out_c     (out_c15),
    .out_ovf   (out_ovf15),
    .ovf_cnt   (ovf_cnt15),
    .clr_ovf   (clr_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact product, round half up, range check, clamp or wrap.
  function automatic void model(input logic signed [15:0] a, input logic signed [15:0] b,
                                input int frac, output logic [15:0] c, output logic ovf);
    longint p, r;
    p = longint'(a) * longint'(b);
    r = (frac > 0) ? ((p + (longint'(1) << (frac - 1))) >>> frac) : p;
    ovf = (r > 32767) || (r < -32768);
`ifdef FXP_MULT_SAT_EN
    c = ovf ? ((r > 0) ? 16'h7FFF : 16'h8000) : r[15:0];
`else
    c = r[15:0];
`endif
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          t;
  } item_t;

  item_t       q[$];
  int          adv = 0;
  int          cyc = 0;
  int          n_dut_out = 0;
  logic        exp_valid = 1'b0;
  logic [15:0] cnt0 = 0, cnt15 = 0;

  // Model update: accepted items travel STAGES advancing edges, leave on output transfer.
  always @(posedge clk) begin
    logic [15:0] c;
    logic        o0, o15;
    logic        m_en, m_xfer;
    cyc++;
    if (!rst && out_valid0 && out_ready) n_dut_out++;
    if (rst) begin
      q.delete();
      adv   = 0;
      cnt0  = 0;
      cnt15 = 0;
    end else begin
      m_en   = !(exp_valid && !out_ready);
      m_xfer = exp_valid && out_ready;
      o0 = 1'b0;
      o15 = 1'b0;
      if (m_xfer) begin
        model(q[0].a, q[0].b, 0, c, o0);
        model(q[0].a, q[0].b, 15, c, o15);
      end
      if (clr_ovf) cnt0 = 0;
      else if (m_xfer && o0 && cnt0 != 16'hFFFF) cnt0++;
      if (clr_ovf) cnt15 = 0;
      else if (m_xfer && o15 && cnt15 != 16'hFFFF) cnt15++;
      if (m_xfer) void'(q.pop_front());
      if (m_en) begin
        if (in_valid) q.push_back('{in_a, in_b, adv});
        adv++;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] c;
    logic        o;
    if (rst) begin
      exp_valid = 1'b0;
    end else begin
      exp_valid = (q.size() > 0) && (adv - q[0].t == STAGES);
      check("out_valid_f0", out_valid0, exp_valid);
      check("out_valid_f15", out_valid15, exp_valid);
      check("in_ready_f0", in_ready0, !(exp_valid && !out_ready));
      check("in_ready_f15", in_ready15, !(exp_valid && !out_ready));
      if (exp_valid) begin
        model(q[0].a, q[0].b, 0, c, o);
        check("out_c_f0", out_c0, c);
        check("out_ovf_f0", out_ovf0, o);
        model(q[0].a, q[0].b, 15, c, o);
        check("out_c_f15", out_c15, c);
        check("out_ovf_f15", out_ovf15, o);
      end
      check("ovf_cnt_f0", ovf_cnt0, cnt0);
      check("ovf_cnt_f15", ovf_cnt15, cnt15);
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, output int acc_cyc);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    acc_cyc  = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready0) begin
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("send_timeout", 1'b1, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic pin(input string name, input logic [15:0] a, input logic [15:0] b,
                     input int frac, input logic [15:0] exp_c, input logic exp_o);
    logic [15:0] c;
    logic        o;
    model(a, b, frac, c, o);
    check({name, "_c"}, c, exp_c);
    check({name, "_ovf"}, o, exp_o);
  endtask

  logic [15:0] dir_a[9] = '{16'd10, 16'd8, -16'sd3731, 16'd1, 16'd300,
                            16'h4000, 16'h0001, 16'hFFFF, 16'h8000};
  logic [15:0] dir_b[9] = '{16'd10, -16'sd8, 16'd8, 16'd0, 16'd300,
                            16'h4000, 16'h4000, 16'h4000, 16'h8000};
  logic [15:0] corner[6] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h0000, 16'h4000};

  initial begin
    int acc;
    int base;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    clr_ovf   = 1'b0;

    // Hand-computed values that pin the reference model.
    pin("pin_10x10", 16'd10, 16'd10, 0, 16'd100, 1'b0);
    pin("pin_8xm8", 16'd8, -16'sd8, 0, 16'hFFC0, 1'b0);
    pin("pin_m3731x8", -16'sd3731, 16'd8, 0, 16'h8B68, 1'b0);
    pin("pin_1x0", 16'd1, 16'd0, 0, 16'h0000, 1'b0);
`ifdef FXP_MULT_SAT_EN
    pin("pin_300x300", 16'd300, 16'd300, 0, 16'h7FFF, 1'b1);
    pin("pin_q15_min_sq", 16'h8000, 16'h8000, 15, 16'h7FFF, 1'b1);
`else
    pin("pin_300x300", 16'd300, 16'd300, 0, 16'd24464, 1'b1);
    pin("pin_q15_min_sq", 16'h8000, 16'h8000, 15, 16'h8000, 1'b1);
`endif
    pin("pin_q15_half_sq", 16'h4000, 16'h4000, 15, 16'h2000, 1'b0);
    pin("pin_q15_half_up", 16'h0001, 16'h4000, 15, 16'h0001, 1'b0);
    pin("pin_q15_neg_tiny", 16'hFFFF, 16'h4000, 15, 16'h0000, 1'b0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_out_c", out_c0, 16'h0000);
    check("rst_out_ovf", out_ovf0, 1'b0);
    check("rst_ovf_cnt", ovf_cnt0, 16'h0000);
    check("rst_in_ready", in_ready0, 1'b1);
    @(posedge clk);
    #1;

    // Latency from an empty pipeline.
    send(dir_a[0], dir_b[0], acc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid0) break;
    end
    check("latency", cyc - acc, STAGES);
    @(posedge clk);
    #1;

    for (int i = 1; i < 9; i++) send(dir_a[i], dir_b[i], acc);
    repeat (STAGES + 2) @(posedge clk);
    #1;

    // Eight back-to-back operands with a four-cycle output stall in the middle.
    base = n_dut_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'(i * 1234 + 7), 16'(16'h8000 + i * 4001), acc);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (STAGES + 3) @(posedge clk);
    #1;
    check("stall_result_count", n_dut_out - base, 8);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_a      = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      in_b      = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_ovf   = 1'b0;
    repeat (STAGES + 3) @(posedge clk);
    #1;

    // Asynchronous reset with three operands in flight.
    send(16'h8000, 16'h8000, acc);
    send(16'd300, 16'd300, acc);
    send(16'h7FFF, 16'h7FFF, acc);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid_f0", out_valid0, 1'b0);
    check("midrst_out_valid_f15", out_valid15, 1'b0);
    check("midrst_ovf_cnt", ovf_cnt0, 16'h0000);
    base = n_dut_out;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (STAGES + 5) @(posedge clk);
    #1;
    check("midrst_no_stale", n_dut_out - base, 0);

    // Counter saturation: more than 0xFFFF overflowing transfers.
    in_valid = 1'b1;
    in_a     = 16'h8000;
    in_b     = 16'h8000;
    repeat (65540) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (STAGES + 3) @(posedge clk);
    @(negedge clk);
    check("sat_cnt_f0", ovf_cnt0, 16'hFFFF);
    check("sat_cnt_f15", ovf_cnt15, 16'hFFFF);
    @(posedge clk);
    #1;

    // Clear wins over a same-cycle overflow transfer.
    send(16'h8000, 16'h8000, acc);
    repeat (STAGES - 1) @(posedge clk);
    #1 clr_ovf = 1'b1;
    @(negedge clk);
    check("clr_xfer_valid", out_valid0, 1'b1);
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    @(negedge clk);
    check("clr_priority_f0", ovf_cnt0, 16'h0000);
    check("clr_priority_f15", ovf_cnt15, 16'h0000);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
